// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access size
// encoding and the misalignment test.
package lsu_pkg;

    localparam int BYTE_W = 8;
    localparam int NBYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACC1,
        ACC2,
        FIN
    } state_t;

    // Encoded so the value equals the size in bytes and the one-hot size flags
    typedef enum logic [2:0] {
        SZ_B = 3'd1,
        SZ_H = 3'd2,
        SZ_W = 3'd4
    } size_t;

    function automatic logic crosses(input logic [1:0] off, input size_t sz);
        return ({2'b00, off} + {1'b0, sz}) > 4'd4;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: byte enables and write data for both word
// halves of an access, plus alignment and extension of the load result.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  size_t       size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] lo,
    input  logic [23:0] hi,
    output logic [3:0]  be_lo,
    output logic [3:0]  be_hi,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] load_data
);

    logic [3:0]  mask;
    logic [7:0]  be_full;
    logic [63:0] wdata_full;
    logic [31:0] load_word;

    always_comb begin
        mask = 4'hF;
        case (size)
            SZ_B:    mask = 4'h1;
            SZ_H:    mask = 4'h3;
            default: mask = 4'hF;
        endcase

        be_full    = {4'b0000, mask} << off;
        be_lo      = be_full[3:0];
        be_hi      = be_full[7:4];

        wdata_full = {32'h0, wdata} << (int'(off) * BYTE_W);
        wdata_lo   = wdata_full[31:0];
        wdata_hi   = wdata_full[63:32];

        // The top byte of the second word is never reachable with off<=3, n<=4
        load_word = lo;
        case (off)
            2'd0:    load_word = lo;
            2'd1:    load_word = {hi[7:0],  lo[31:8]};
            2'd2:    load_word = {hi[15:0], lo[31:16]};
            default: load_word = {hi[23:0], lo[31:24]};
        endcase

        load_data = load_word;
        case (size)
            SZ_B:    load_data = {{24{sign_ext & load_word[7]}},  load_word[7:0]};
            SZ_H:    load_data = {{16{sign_ext & load_word[15]}}, load_word[15:0]};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Multicycle load/store unit: turns one byte/half/word request into one or two
// byte-enabled word transactions on a handshaked data memory.
module lsu_mem_ctrl #(
    parameter int WIDTH  = 32,
    parameter int NBYTES = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              one_byte,
    input  logic              two_bytes,
    input  logic              four_bytes,
    input  logic              sign_ext,
    input  logic [WIDTH-1:0]  addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic              done,
    output logic              busy,
    output logic              err,
    output logic              dm_req,
    output logic              dm_we,
    output logic [WIDTH-1:0]  dm_addr,
    output logic [NBYTES-1:0] dm_be,
    output logic [WIDTH-1:0]  dm_wdata,
    input  logic [WIDTH-1:0]  dm_rdata,
    input  logic              dm_ack
);

    import lsu_pkg::*;

    state_t      state;
    size_t       size_in;
    size_t       size_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        sign_q;
    logic        write_q;
    logic        cross_q;
    logic        illegal_q;
    logic [31:0] lo_q;
    logic [23:0] hi_q;
    logic        legal_in;

    logic [1:0]  al_off;
    size_t       al_size;
    logic [31:0] al_wdata;
    logic [3:0]  be_lo;
    logic [3:0]  be_hi;
    logic [31:0] wdata_lo;
    logic [31:0] wdata_hi;
    logic [31:0] load_data;

    assign size_in  = size_t'({four_bytes, two_bytes, one_byte});
    assign legal_in = (mem_read ^ mem_write) && (size_in inside {SZ_B, SZ_H, SZ_W});

    // In IDLE the aligner sees the live request so ACC1 outputs can be registered on accept
    assign al_off   = (state == IDLE) ? addr[1:0] : off_q;
    assign al_size  = (state == IDLE) ? size_in   : size_q;
    assign al_wdata = (state == IDLE) ? wdata     : wdata_q;

    lsu_align u_align (
        .off       (al_off),
        .size      (al_size),
        .sign_ext  (sign_q),
        .wdata     (al_wdata),
        .lo        (lo_q),
        .hi        (hi_q),
        .be_lo     (be_lo),
        .be_hi     (be_hi),
        .wdata_lo  (wdata_lo),
        .wdata_hi  (wdata_hi),
        .load_data (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdata     <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_be     <= '0;
            dm_wdata  <= '0;
            size_q    <= SZ_W;
            off_q     <= 2'b00;
            wdata_q   <= '0;
            sign_q    <= 1'b0;
            write_q   <= 1'b0;
            cross_q   <= 1'b0;
            illegal_q <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        size_q    <= size_in;
                        off_q     <= addr[1:0];
                        wdata_q   <= wdata;
                        sign_q    <= sign_ext;
                        write_q   <= mem_write;
                        cross_q   <= crosses(addr[1:0], size_in);
                        illegal_q <= !legal_in;
                        hi_q      <= '0;
                        busy      <= 1'b1;
                        if (legal_in) begin
                            state    <= ACC1;
                            dm_req   <= 1'b1;
                            dm_we    <= mem_write;
                            dm_addr  <= {addr[WIDTH-1:2], 2'b00};
                            dm_be    <= be_lo;
                            dm_wdata <= wdata_lo;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                ACC1: begin
                    if (dm_ack) begin
                        lo_q <= dm_rdata;
                        if (cross_q) begin
                            state    <= ACC2;
                            dm_addr  <= dm_addr + WIDTH'(4);
                            dm_be    <= be_hi;
                            dm_wdata <= wdata_hi;
                        end else begin
                            state  <= FIN;
                            dm_req <= 1'b0;
                            dm_we  <= 1'b0;
                        end
                    end
                end
                ACC2: begin
                    if (dm_ack) begin
                        hi_q   <= dm_rdata[23:0];
                        state  <= FIN;
                        dm_req <= 1'b0;
                        dm_we  <= 1'b0;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    err   <= illegal_q;
                    busy  <= 1'b0;
                    state <= IDLE;
                    // rdata is only disturbed by a successful load
                    if (!illegal_q && !write_q) begin
                        rdata <= load_data;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
